adder_4bits: RTL and testbench

- Registered 4-bit two's-complement / unsigned ripple-carry adder with carry-in.
- Produces sum, carry-out and signed-overflow flag.
- Datapath primitive used wherever a small registered add with status flags is needed.
- Single clock domain; outputs valid one cycle after inputs are sampled.

---
 rtl/adder_4bits.sv | 59 +++++
 tb/tb_adder_4bits.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/adder_4bits.sv
// Registered ripple-carry adder with carry-in. It produces sum, carry-out and signed overflow.
// The outputs update on every rising clock edge. Reset is synchronous and active-high.
module adder_4bits #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] Sum,
   output logic             cout,
   output logic             overflow
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   // NOTE: the carry chain is built in a single always_comb block using blocking assignments.
   // Each stage reads the carry that the previous iteration just wrote.
   // Every variable gets a default first, so no latch is inferred.
   always_comb begin
      carry    = '0;
      sum_d    = '0;
      carry[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i]   = A[i] ^ B[i] ^ carry[i];
         carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
      end
      cout_d = carry[WIDTH];
      // Signed overflow: the carry into the sign bit disagrees with the carry out of it.
      ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
   end

   // NOTE: state registers use non-blocking assignments only.
   // Reset takes priority, and the operands presented on a reset edge are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign Sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_4bits.sv
// Self-checking bench for adder_4bits.
// It combines directed literal vectors with an arithmetic reference model that is compared on every cycle.
module tb_adder_4bits;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       cin;
   logic [3:0] Sum;
   logic       cout;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_sum;
   logic       exp_cout;
   logic       exp_ovf;
   logic       exp_valid = 1'b0;

   adder_4bits #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .cin      (cin),
      .Sum      (Sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: plain integer addition, with overflow taken from the operand and result sign rule.
   function automatic logic [5:0] golden(input logic [3:0] a, input logic [3:0] b, input logic ci);
      int         r;
      logic [3:0] s;
      logic       ov;
      r  = int'(a) + int'(b) + int'(ci);
      s  = 4'(r % 16);
      ov = (a[3] == b[3]) && (s[3] != a[3]);
      return {ov, (r >= 16), s};
   endfunction

   always @(posedge clk) begin
      logic [5:0] g;
      g = golden(A, B, cin);
      if (rst) begin
         exp_sum   <= 4'h0;
         exp_cout  <= 1'b0;
         exp_ovf   <= 1'b0;
         exp_valid <= 1'b1;
      end else if (exp_valid) begin
         exp_sum  <= g[3:0];
         exp_cout <= g[4];
         exp_ovf  <= g[5];
      end
   end

   always @(negedge clk) begin
      if (exp_valid) begin
         check("model_sum",  32'(Sum),      32'(exp_sum));
         check("model_cout", 32'(cout),     32'(exp_cout));
         check("model_ovf",  32'(overflow), 32'(exp_ovf));
      end
   end

   // Entered at a negedge. It applies one vector, waits one edge, and then checks both the DUT and the model against the literals.
   task automatic vec(input string name, input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec, input logic eo);
      A   = a;
      B   = b;
      cin = ci;
      @(negedge clk);
      check({name, "_sum"},  32'(Sum),      32'(es));
      check({name, "_cout"}, 32'(cout),     32'(ec));
      check({name, "_ovf"},  32'(overflow), 32'(eo));
      check({name, "_model"}, 32'({exp_ovf, exp_cout, exp_sum}), 32'({eo, ec, es}));
   endtask

   initial begin
      rst = 1'b1;
      A   = 4'hF;
      B   = 4'hF;
      cin = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_sum",  32'(Sum),      32'h0);
      check("reset_cout", 32'(cout),     32'h0);
      check("reset_ovf",  32'(overflow), 32'h0);

      rst = 1'b0;
      vec("post_reset", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

      vec("pos_1_0",   4'd1, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0);
      vec("pos_2_1",   4'd2, 4'd1, 1'b0, 4'd3, 1'b0, 1'b0);
      vec("pos_3_4",   4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);
      vec("pos_5_1",   4'd5, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
      vec("neg_f_9",   4'b1111, 4'b1001, 1'b0, 4'b1000, 1'b1, 1'b0);
      vec("neg_c_c",   4'b1100, 4'b1100, 1'b0, 4'b1000, 1'b1, 1'b0);
      vec("wrap_f_1",  4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
      vec("ovf_7_2",   4'b0111, 4'b0010, 1'b0, 4'b1001, 1'b0, 1'b1);
      vec("ovf_8_8",   4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
      vec("cin_7_0",   4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1);
      vec("cin_f_f",   4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

      // Exhaustive sweep, one combination per cycle. A single reset cycle is inserted in the middle.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v   = 9'(i);
         A   = v[3:0];
         B   = v[7:4];
         cin = v[8];
         rst = (i == 300);
         @(negedge clk);
         if (i == 300) begin
            check("mid_reset_sum",  32'(Sum),      32'h0);
            check("mid_reset_cout", 32'(cout),     32'h0);
            check("mid_reset_ovf",  32'(overflow), 32'h0);
         end
      end
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
